// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared types and constants for the HI/LO multiply/divide unit.
// Holds the op and FSM state enums, OP_W and the start-to-done latency helper.
package muldiv_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        MULT  = 3'd0,
        MULTU = 3'd1,
        DIV   = 3'd2,
        DIVU  = 3'd3,
        MTHI  = 3'd4,
        MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIXUP,
        COMMIT
    } state_e;

    // Cycles from the accepting edge to the edge that commits HI/LO.
    function automatic int muldiv_latency(int width, int cycles_per_bit);
        return width * cycles_per_bit + 2;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: request/result bundle between the pipeline and muldiv_unit.
// master drives start/op/a/b/flush; slave returns ready/done/stall/hi/lo/div_zero.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    import muldiv_pkg::*;

    logic             start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             ready;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_zero;

    modport master (
        output start, op, a, b, flush,
        input  ready, done, stall, hi, lo, div_zero
    );

    modport slave (
        input  start, op, a, b, flush,
        output ready, done, stall, hi, lo, div_zero
    );

endinterface

// File: rtl/muldiv_core.sv
// muldiv_core: shared iterative datapath, one shift-add or restoring
// shift-subtract step per step pulse. Ports: load/step, magnitudes in, acc/quo out.
// The divide step exists only when MULDIV_DIVIDE_EN is defined.
module muldiv_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
`ifdef MULDIV_DIVIDE_EN
    input  logic             is_div,
`endif
    input  logic [WIDTH-1:0] a_mag,
    input  logic [WIDTH-1:0] b_mag,
    output logic [WIDTH-1:0] acc,
    output logic [WIDTH-1:0] quo
);
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [WIDTH-1:0] addend;

`ifdef MULDIV_DIVIDE_EN
    logic [WIDTH:0]   x;
    logic [WIDTH+1:0] sum;

    // One adder: divide inverts the addend and carries in, giving x - m.
    // sum[WIDTH+1] is then the borrow (trial subtract went negative).
    always_comb begin
        x      = is_div ? {acc_q, quo_q[WIDTH-1]} : {1'b0, acc_q};
        addend = (is_div || quo_q[0]) ? m_q : '0;
        sum    = {1'b0, x}
               + ({2'b00, addend} ^ {(WIDTH+2){is_div}})
               + (WIDTH+2)'(is_div);
    end
`else
    logic [WIDTH:0] sum;

    always_comb begin
        addend = quo_q[0] ? m_q : '0;
        sum    = {1'b0, acc_q} + {1'b0, addend};
    end
`endif

    always_comb begin
        acc_d = acc_q;
        quo_d = quo_q;
        m_d   = m_q;
        if (load) begin
            acc_d = '0;
            quo_d = a_mag;
            m_d   = b_mag;
        end else if (step) begin
`ifdef MULDIV_DIVIDE_EN
            if (is_div) begin
                acc_d = sum[WIDTH+1] ? x[WIDTH-1:0] : sum[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ~sum[WIDTH+1]};
            end else begin
                acc_d = sum[WIDTH:1];
                quo_d = {sum[0], quo_q[WIDTH-1:1]};
            end
`else
            acc_d = sum[WIDTH:1];
            quo_d = {sum[0], quo_q[WIDTH-1:1]};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            quo_q <= '0;
            m_q   <= '0;
        end else begin
            acc_q <= acc_d;
            quo_q <= quo_d;
            m_q   <= m_d;
        end
    end

    assign acc = acc_q;
    assign quo = quo_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: MIPS-style HI/LO multiply/divide unit; FSM, signs, HI/LO regs.
// Ports: clk, rst (async active-low), bus (muldiv_if.slave). Macro MULDIV_DIVIDE_EN enables DIV/DIVU.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int CYCLES_PER_BIT = 1
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [2:0]       sub_q, sub_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d, res_lo_q, res_lo_d;
    logic             done_q, done_d, divz_q, divz_d;
    logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
    logic             is_div_q, is_div_d, dz_q, dz_d;

    op_e              op;
    logic             ready, accept, go_mul, go_div, sgn, dz;
    logic             step, last_step;
    logic [WIDTH-1:0] a_mag, b_mag, core_acc, core_quo;
    logic [2*WIDTH-1:0] prod;

    assign op     = op_e'(bus.op);
    assign accept = ready && bus.start && !bus.flush;
    assign go_mul = accept && (op == MULT || op == MULTU);
`ifdef MULDIV_DIVIDE_EN
    assign go_div = accept && (op == DIV || op == DIVU);
`else
    assign go_div = 1'b0;
`endif
    assign sgn    = (op == MULT) || (op == DIV);
    assign dz     = go_div && (bus.b == '0);
    assign a_mag  = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign b_mag  = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;

    assign step      = (state_q == RUN) && (sub_q == 3'(CYCLES_PER_BIT - 1));
    assign last_step = step && (cnt_q == CW'(WIDTH - 1));

    muldiv_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .rst    (rst),
        .load   (go_mul || (go_div && !dz)),
        .step   (step),
`ifdef MULDIV_DIVIDE_EN
        .is_div (is_div_q),
`endif
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .acc    (core_acc),
        .quo    (core_quo)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE:   if (dz) state_d = FIXUP;
                        else if (go_mul || go_div) state_d = RUN;
                RUN:    if (last_step) state_d = FIXUP;
                FIXUP:  state_d = COMMIT;
                COMMIT: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        ready     = (state_q == IDLE);
        bus.ready = ready;
        bus.stall = !ready;
    end

    always_comb begin
        sub_d = '0;
        cnt_d = cnt_q;
        if (accept) cnt_d = '0;
        if (state_q == RUN && !step) sub_d = sub_q + 3'd1;
        if (step) cnt_d = cnt_q + CW'(1);
    end

    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        res_hi_d  = res_hi_q;
        res_lo_d  = res_lo_q;
        done_d    = 1'b0;
        divz_d    = divz_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        is_div_d  = is_div_q;
        dz_d      = dz_q;
        prod      = {core_acc, core_quo};
        if (accept) begin
            divz_d    = 1'b0;
            if (op == MTHI) hi_d = bus.a;
            if (op == MTLO) lo_d = bus.a;
            neg_res_d = sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_rem_d = sgn && bus.a[WIDTH-1];
            is_div_d  = go_div;
            dz_d      = dz;
            // Preloaded divide-by-zero result; FIXUP leaves it alone.
            res_hi_d  = bus.a;
            res_lo_d  = '1;
        end else if (!bus.flush) begin
            if (state_q == FIXUP && !dz_q) begin
                if (is_div_q) begin
                    res_hi_d = neg_rem_q ? -core_acc : core_acc;
                    res_lo_d = neg_res_q ? -core_quo : core_quo;
                end else begin
                    if (neg_res_q) prod = -prod;
                    res_hi_d = prod[2*WIDTH-1:WIDTH];
                    res_lo_d = prod[WIDTH-1:0];
                end
            end
            if (state_q == COMMIT) begin
                hi_d   = res_hi_q;
                lo_d   = res_lo_q;
                done_d = 1'b1;
                divz_d = dz_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sub_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            res_hi_q  <= '0;
            res_lo_q  <= '0;
            done_q    <= 1'b0;
            divz_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            is_div_q  <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            sub_q     <= sub_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            res_hi_q  <= res_hi_d;
            res_lo_q  <= res_lo_d;
            done_q    <= done_d;
            divz_q    <= divz_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            is_div_q  <= is_div_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.done     = done_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.div_zero = divz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: vector table, hand sequences and random ops against an
// arithmetic reference model; second instance checks WIDTH=16, CYCLES_PER_BIT=3.
module tb_muldiv_unit;
    import muldiv_pkg::*;

`ifdef MULDIV_DIVIDE_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct {
        op_e         op;
        logic [31:0] a, b, hi, lo;
        logic        dz;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        logic        dz;
        bit          fires;
    } res_t;

    logic clk, rst;
    int   checks, failures;
    logic [31:0] exp_hi, exp_lo;

    muldiv_if #(.WIDTH(32)) bus ();
    muldiv_if #(.WIDTH(16)) bus2 ();

    muldiv_unit #(.WIDTH(32), .CYCLES_PER_BIT(1)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    muldiv_unit #(.WIDTH(16), .CYCLES_PER_BIT(3)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic res_t ref_op(op_e op, logic [31:0] a, logic [31:0] b,
                                    logic [31:0] hi, logic [31:0] lo);
        res_t r;
        longint p, m;
        logic [63:0] u;
        r.hi = hi; r.lo = lo; r.dz = 1'b0; r.fires = 1'b0;
        case (op)
            MULT: begin
                p = longint'($signed(a)) * longint'($signed(b));
                r.hi = p[63:32]; r.lo = p[31:0]; r.fires = 1'b1;
            end
            MULTU: begin
                u = 64'(a) * 64'(b);
                r.hi = u[63:32]; r.lo = u[31:0]; r.fires = 1'b1;
            end
            DIV, DIVU: begin
                if (DIV_EN) begin
                    r.fires = 1'b1;
                    if (b == 0) begin
                        r.hi = a; r.lo = '1; r.dz = 1'b1;
                    end else if (op == DIV) begin
                        p = longint'($signed(a)) / longint'($signed(b));
                        m = longint'($signed(a)) % longint'($signed(b));
                        r.lo = p[31:0]; r.hi = m[31:0];
                    end else begin
                        u = 64'(a) / 64'(b);
                        r.lo = u[31:0];
                        u = 64'(a) % 64'(b);
                        r.hi = u[31:0];
                    end
                end
            end
            MTHI: r.hi = a;
            MTLO: r.lo = a;
            default: ;
        endcase
        return r;
    endfunction

    // Called at the first negedge after the accepting edge.
    task automatic finish_op(input string nm, input logic [31:0] ehi,
                             input logic [31:0] elo, input logic edz,
                             input bit fires, input int elat, input int junk);
        int n, st;
        bit seen;
        n = 0; st = 0; seen = 1'b0;
        if (fires) begin
            while (!seen && n < 100) begin
                bus.start = (n < junk);
                bus.op = op_e'($urandom_range(0, 5));
                bus.a = $urandom;
                bus.b = $urandom;
                if (bus.done) seen = 1'b1;
                else begin
                    if (bus.stall) st++;
                    @(negedge clk);
                    n++;
                end
            end
            bus.start = 1'b0;
            check({nm, "_lat"}, n, elat);
            check({nm, "_stall"}, st, elat);
        end else begin
            bus.start = 1'b0;
            repeat (40) begin
                bus.a = $urandom;
                bus.b = $urandom;
                if (bus.done) seen = 1'b1;
                if (bus.stall) st++;
                @(negedge clk);
            end
            check({nm, "_nodone"}, seen, 0);
            check({nm, "_nostall"}, st, 0);
        end
        check({nm, "_hi"}, bus.hi, ehi);
        check({nm, "_lo"}, bus.lo, elo);
        check({nm, "_dz"}, bus.div_zero, edz);
    endtask

    task automatic do_op(input string nm, input op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ehi,
                         input logic [31:0] elo, input logic edz,
                         input bit fires, input int elat, input int junk);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        @(negedge clk);
        finish_op(nm, ehi, elo, edz, fires, elat, junk);
    endtask

    vec_t tbl [11];

    initial begin
        vec_t v;
        res_t r;
        logic [31:0] ehi, elo;
        logic edz;
        bit fires, seen;
        int n, lat;
        op_e rop;
        logic [31:0] ra, rb;

        checks = 0; failures = 0;
        rst = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        bus2.start = 1'b0; bus2.op = '0; bus2.a = '0; bus2.b = '0;
        bus2.flush = 1'b0;

        tbl[0]  = '{MULT,  32'hFFFFFFFD, 32'd7,       32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34};
        tbl[1]  = '{DIV,   32'hFFFFFFF9, 32'd2,       32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 34};
        tbl[2]  = '{DIVU,  32'd7,        32'd2,       32'd1,        32'd3,        1'b0, 34};
        tbl[3]  = '{DIVU,  32'h1234,     32'd0,       32'h1234,     32'hFFFFFFFF, 1'b1, 2};
        tbl[4]  = '{MULTU, 32'd3,        32'd5,       32'd0,        32'd15,       1'b0, 34};
        tbl[5]  = '{DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,       32'h80000000, 1'b0, 34};
        tbl[6]  = '{MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0,       1'b0, 34};
        tbl[7]  = '{DIV,   32'd7,        32'hFFFFFFFE, 32'd1,       32'hFFFFFFFD, 1'b0, 34};
        tbl[8]  = '{DIV,   32'hFFFFFFF9, 32'd0,       32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 2};
        tbl[9]  = '{MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 34};
        tbl[10] = '{DIVU,  32'hFFFFFFFF, 32'd16,      32'hF,        32'h0FFFFFFF, 1'b0, 34};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", bus.ready, 1);
        check("rst_stall", bus.stall, 0);
        check("rst_done", bus.done, 0);
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_dz", bus.div_zero, 0);
        rst = 1'b1;
        exp_hi = '0; exp_lo = '0;

        // Vector table
        for (int i = 0; i < 11; i++) begin
            v = tbl[i];
            if ((v.op == DIV || v.op == DIVU) && !DIV_EN) begin
                ehi = exp_hi; elo = exp_lo; edz = 1'b0; fires = 1'b0;
            end else begin
                ehi = v.hi; elo = v.lo; edz = v.dz; fires = 1'b1;
            end
            do_op($sformatf("vec%0d", i), v.op, v.a, v.b,
                  ehi, elo, edz, fires, v.lat, 0);
            exp_hi = ehi; exp_lo = elo;
        end

        // Extra starts during RUN are ignored
        do_op("multu_max", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
              32'hFFFFFFFE, 32'h1, 1'b0, 1'b1, 34, 10);

        // MTHI then flushed MULT
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        do_op("mthi", MTHI, 32'hA5A5A5A5, 32'h0, 32'hA5A5A5A5, 32'h0,
              1'b0, 1'b0, 0, 0);
        do_op("mtlo", MTLO, 32'h0BADF00D, 32'h0, 32'hA5A5A5A5, 32'h0BADF00D,
              1'b0, 1'b0, 0, 0);
        do_op("mtlo0", MTLO, 32'h0, 32'h0, 32'hA5A5A5A5, 32'h0,
              1'b0, 1'b0, 0, 0);
        @(negedge clk);
        bus.start = 1'b1; bus.op = MULT; bus.a = 32'd5; bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_ready", bus.ready, 1);
        seen = 1'b0;
        repeat (40) begin
            if (bus.done) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_nodone", seen, 0);
        check("flush_hi", bus.hi, 32'hA5A5A5A5);
        check("flush_lo", bus.lo, 32'h0);

        // Flush together with start drops the start
        bus.start = 1'b1; bus.op = MTLO; bus.a = 32'h12345678; bus.flush = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        @(negedge clk);
        check("flush_start_lo", bus.lo, 32'h0);
        check("flush_start_ready", bus.ready, 1);

        // Flush while in COMMIT
        bus.start = 1'b1; bus.op = MULTU; bus.a = 32'd2; bus.b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (33) @(negedge clk);
        check("commit_stall", bus.stall, 1);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("commit_flush_done", bus.done, 0);
        check("commit_flush_ready", bus.ready, 1);
        @(negedge clk);
        check("commit_flush_done2", bus.done, 0);
        check("commit_flush_lo", bus.lo, 32'h0);
        check("commit_flush_hi", bus.hi, 32'hA5A5A5A5);

        // Reset mid-RUN, then start on the first cycle after release
        bus.start = 1'b1; bus.op = MULT; bus.a = 32'd5; bus.b = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_hi", bus.hi, 32'h0);
        check("midrst_lo", bus.lo, 32'h0);
        check("midrst_ready", bus.ready, 1);
        rst = 1'b1;
        bus.start = 1'b1; bus.op = MULTU; bus.a = 32'd3; bus.b = 32'd4;
        @(negedge clk);
        finish_op("after_rst", 32'h0, 32'd12, 1'b0, 1'b1, 34, 0);
        exp_hi = 32'h0; exp_lo = 32'd12;

        // Random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            rop = op_e'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            if ($urandom_range(0, 5) == 0) rb = -rb;
            r = ref_op(rop, ra, rb, exp_hi, exp_lo);
            lat = r.dz ? 2 : 34;
            do_op($sformatf("rnd%0d", i), rop, ra, rb,
                  r.hi, r.lo, r.dz, r.fires, lat, 0);
            exp_hi = r.hi; exp_lo = r.lo;
        end

        // WIDTH=16, CYCLES_PER_BIT=3 instance
        @(negedge clk);
        bus2.start = 1'b1; bus2.op = MULTU; bus2.a = 16'd300; bus2.b = 16'd300;
        @(negedge clk);
        bus2.start = 1'b0;
        bus2.a = 16'hFFFF; bus2.b = 16'h1234;
        n = 0;
        while (!bus2.done && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("w16_lat", n, 50);
        check("w16_hi", bus2.hi, 16'h0001);
        check("w16_lo", bus2.lo, 16'h5F90);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
